serial_tcmp_deserializer: RTL and testbench
===========================================

# serial_tcmp_deserializer

Receive end of the LSB-first serial datapath used by the serial-parallel multiplier. The block collects a WIDTH-bit serial word, optionally two's-complements it on the fly, and presents the assembled parallel word with a valid/ready handshake. It pairs with the bit-serial two's-complement stage: the serial-domain operation is finished here and the result is returned to the parallel domain.

## Interface
Parameters:
- WIDTH, 16, number of serial bits per word (product width); must be ≥ 2
- CW, $clog2(WIDTH), bit counter width

Ports:
- clk  input  1  global clock, rising-edge
- rst  input  1  global reset, asynchronous, active-low (0 = reset)
- start  input  1  begin capture; accepted only in IDLE
- neg  input  1  sampled with start; 1 = output the two's complement of the received word
- sin  input  1  serial data, LSB first, one bit per cycle
- busy  output  1  high while in SHIFT
- valid  output  1  dout holds a completed word
- ready  input  1  consumer accepts dout when valid & ready
- dout  output  WIDTH  assembled parallel word

## Operation
- One clock; rst low asynchronously forces state=IDLE and all registers to 0. Reset values: busy=0, valid=0, dout=0. Counter, shift register, neg_r and the first-one flag z are also 0.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE: if start=1, set neg_r<=neg, z<=0, cnt<=0, sr<=0, and go to SHIFT. Otherwise stay. sin is ignored.
- SHIFT: each cycle, consume sin:
  - b = neg_r ? (sin ^ z) : sin
  - z <= z | sin
  - sr <= {b, sr[WIDTH-1:1]}
  - cnt <= cnt+1
  - When cnt==WIDTH-1, the bit is the MSB. Load dout <= {b, sr[WIDTH-1:1]}, set valid<=1, and go to HOLD.
- HOLD: valid=1 and dout stable. When ready=1, set valid<=0 and go to IDLE. dout keeps its last value after the handshake.
- start is ignored in SHIFT and HOLD, including a start in the same cycle as the HOLD ready handshake. A new capture needs start in IDLE.
- ready is ignored outside HOLD.
- Arithmetic: the result is modulo 2^WIDTH with no overflow flag.
  - Negating 0 gives 0.
  - Negating 100…0 (most-negative value) gives 100…0.
- Reset mid-SHIFT or mid-HOLD aborts the word. There is no partial output, valid is 0 immediately, and the block is in IDLE after rst is released.

## Timing
- Cycle n: start=1 sampled in IDLE.
- Cycles n+1 … n+WIDTH: sin bit 0 … bit WIDTH-1 sampled. busy=1 during these cycles.
- Cycle n+WIDTH+1: valid=1 and dout valid. Latency from start to valid is WIDTH+1 cycles.
- With ready held high, valid is high for exactly 1 cycle. The next start is accepted at cycle n+WIDTH+2 at the earliest, which gives throughput of one word per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- WIDTH=8, neg=0, serial 0x05 (bits 1,0,1,0,0,0,0,0), ready=1 -> valid exactly 9 cycles after start, dout=0x05, busy high 8 cycles.
- WIDTH=8, neg=1, words 0x05, 0x00, 0x80, 0xFF -> dout 0xFB, 0x00, 0x80, 0x01 respectively.
- Backpressure: ready low for 5 cycles after valid -> valid and dout stay stable. A start pulse during HOLD is ignored. Raising ready returns the block to IDLE and valid drops the next cycle.
- start pulses and sin toggles during SHIFT -> captured word unaffected and no restart. neg changing mid-word -> no effect, because neg_r is latched at start.
- rst driven low after bit 3 of a word -> valid=0, busy=0, dout=0 immediately. A fresh start after release of 0x3C with neg=0 -> dout=0x3C.
- Back-to-back: 100 random words with random neg and random ready delays, checked against a model (neg ? -x : x) mod 256.

Source files
------------

// File: rtl/serial_tcmp_deserializer_if.sv
// Handshake and serial-data bundle between a serial source/consumer and the
// deserializer. The master side drives the serial word and accepts dout.
interface serial_tcmp_deserializer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             neg;
  logic             sin;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] dout;

  modport master (output start, neg, sin, ready, input  busy, valid, dout);
  modport slave  (input  start, neg, sin, ready, output busy, valid, dout);
endinterface

// File: rtl/serial_tcmp_deserializer.sv
// LSB-first serial-to-parallel receiver with optional on-the-fly two's
// complement, presenting the finished word on a valid/ready handshake.
module serial_tcmp_deserializer #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input logic                    clk,
  input logic                    rst,
  serial_tcmp_deserializer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] sr;
  logic             neg_r;
  logic             z;
  logic             busy_r;
  logic             valid_r;
  logic [WIDTH-1:0] dout_r;
  logic             b;
  logic [WIDTH-1:0] shifted;

  // Serial negate: copy bits up to and including the first 1, invert the rest.
  assign b       = neg_r ? (bus.sin ^ z) : bus.sin;
  assign shifted = {b, sr};

  assign bus.busy  = busy_r;
  assign bus.valid = valid_r;
  assign bus.dout  = dout_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      neg_r   <= 1'b0;
      z       <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      dout_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_r  <= bus.neg;
            z      <= 1'b0;
            cnt    <= '0;
            sr     <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          z   <= z | bus.sin;
          sr  <= shifted[WIDTH-1:1];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            dout_r  <= shifted;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tcmp_deserializer.sv
// Directed + randomized bench for the serial deserializer; expectations come
// from word-level arithmetic and the start-to-valid timing contract.
module tb_serial_tcmp_deserializer;
  localparam int W = 8;

  logic clk;
  logic rst;
  serial_tcmp_deserializer_if #(.WIDTH(W)) bus();

  serial_tcmp_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         exp_busy;
  logic         exp_valid;
  logic [W-1:0] exp_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Outputs are registered, so mid-cycle sampling sees the post-edge values.
  always @(negedge clk) begin
    chk("busy",  32'(bus.busy),  32'(exp_busy));
    chk("valid", 32'(bus.valid), 32'(exp_valid));
    chk("dout",  32'(bus.dout),  32'(exp_dout));
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic n);
    int v;
    v = n ? (256 - int'(x)) % 256 : int'(x);
    return v[W-1:0];
  endfunction

  // One full word: start, W serial bits, then rdly cycles of backpressure.
  // noise toggles start/neg/sin where they must be ignored.
  task automatic send(input logic [W-1:0] x, input logic n, input int rdly, input logic noise);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.neg   = n;
    bus.ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(posedge clk); #1;
      bus.start = noise & ((i % 2) == 0);
      if (noise) bus.neg = ~bus.neg;
      bus.ready = 1'($urandom_range(0, 1));
      bus.sin   = x[i];
      exp_busy  = 1'b1;
    end
    @(posedge clk); #1;
    exp_busy  = 1'b0;
    exp_valid = 1'b1;
    exp_dout  = model(x, n);
    bus.sin   = 1'($urandom_range(0, 1));
    for (int k = 0; k <= rdly; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      bus.ready = (k == rdly);
      bus.start = noise;
    end
    @(posedge clk); #1;
    exp_valid = 1'b0;
    bus.start = 1'b0;
    bus.ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.neg   = 1'b0;
    bus.sin   = 1'b0;
    bus.ready = 1'b0;
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    exp_dout  = '0;
    #2;
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_dout",  32'(bus.dout),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Plain capture; per-cycle compare pins 9-cycle latency and 8-cycle busy.
    send(8'h05, 1'b0, 0, 1'b0);
    chk("lit_pos05", 32'(bus.dout), 32'h05);

    send(8'h05, 1'b1, 0, 1'b0);
    chk("lit_neg05", 32'(bus.dout), 32'hFB);
    send(8'h00, 1'b1, 0, 1'b0);
    chk("lit_neg00", 32'(bus.dout), 32'h00);
    send(8'h80, 1'b1, 0, 1'b0);
    chk("lit_neg80", 32'(bus.dout), 32'h80);
    send(8'hFF, 1'b1, 0, 1'b0);
    chk("lit_negFF", 32'(bus.dout), 32'h01);

    // Backpressure with start pulses in HOLD and on the handshake cycle.
    send(8'hA7, 1'b0, 5, 1'b1);
    chk("lit_bp_A7", 32'(bus.dout), 32'hA7);
    send(8'h36, 1'b1, 2, 1'b1);
    chk("lit_noise_neg36", 32'(bus.dout), 32'hCA);

    // Abort after bit 3 of a word: everything clears asynchronously.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.neg   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.sin   = i[0];
      exp_busy  = 1'b1;
    end
    @(posedge clk); #2;
    rst       = 1'b0;
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    exp_dout  = '0;
    #1;
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_valid", 32'(bus.valid), 32'd0);
    chk("abort_dout",  32'(bus.dout),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(8'h3C, 1'b0, 1, 1'b0);
    chk("lit_after_abort", 32'(bus.dout), 32'h3C);

    for (int r = 0; r < 100; r++)
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
